// File: rtl/ibex_fp_cvt_arbiter.sv
// Round-robin arbiter sharing one int2float converter between two requesters.
// Optional watchdog on the converter wait: define IBEX_FP_CVT_TIMEOUT_EN.
module ibex_fp_cvt_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  req_valid_i,
  input  logic [31:0] req_data0_i,
  input  logic [31:0] req_data1_i,
  output logic [1:0]  req_ready_o,
  output logic        cvt_en_o,
  output logic [31:0] cvt_a_o,
  input  logic [31:0] cvt_z_i,
  input  logic        cvt_valid_i,
  output logic        rsp_valid_o,
  output logic        rsp_id_o,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o,
  input  logic        rsp_ready_i,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    DRAIN
  } state_e;

  state_e      state_q, state_d;
  logic        rr_q, rr_d;
  logic        id_q, id_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] res_q, res_d;
  logic        gnt;

`ifdef IBEX_FP_CVT_TIMEOUT_EN
  localparam logic [7:0] ToLim = 8'(TIMEOUT_CYCLES);
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // Grant: pointer's port if it asks, else the other one
  always_comb begin
    gnt = rr_q;
    if (!req_valid_i[rr_q]) gnt = ~rr_q;
  end

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    id_d        = id_q;
    opa_d       = opa_q;
    res_d       = res_q;
    req_ready_o = 2'b00;
    cvt_en_o    = 1'b0;
    rsp_valid_o = 1'b0;
`ifdef IBEX_FP_CVT_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|req_valid_i) begin
          req_ready_o = gnt ? 2'b10 : 2'b01;
          opa_d       = gnt ? req_data1_i : req_data0_i;
          id_d        = gnt;
          rr_d        = ~gnt;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        cvt_en_o = 1'b1;
        state_d  = WAIT;
`ifdef IBEX_FP_CVT_TIMEOUT_EN
        cnt_d    = 8'd0;
`endif
      end
      WAIT: begin
        cvt_en_o = 1'b1;
        if (cvt_valid_i) begin
          res_d   = cvt_z_i;
          state_d = RESP;
`ifdef IBEX_FP_CVT_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (cnt_q + 8'd1 == ToLim) begin
          res_d   = 32'h7FC0_0000;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d   = cnt_q + 8'd1;
`endif
        end
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = DRAIN;
      end
      DRAIN: begin
        if (!cvt_valid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      id_q    <= 1'b0;
      opa_q   <= 32'd0;
      res_q   <= 32'd0;
`ifdef IBEX_FP_CVT_TIMEOUT_EN
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      opa_q   <= opa_d;
      res_q   <= res_d;
`ifdef IBEX_FP_CVT_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign cvt_a_o    = opa_q;
  assign rsp_id_o   = id_q;
  assign rsp_data_o = res_q;
  assign busy_o     = (state_q != IDLE);
`ifdef IBEX_FP_CVT_TIMEOUT_EN
  assign rsp_err_o  = err_q;
`else
  assign rsp_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_ibex_fp_cvt_arbiter.sv
// Scoreboard bench for ibex_fp_cvt_arbiter with a behavioural converter.
// Timeout case runs only when IBEX_FP_CVT_TIMEOUT_EN is defined.
module tb_ibex_fp_cvt_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid_i;
  logic [31:0] req_data0_i, req_data1_i;
  logic [1:0]  req_ready_o;
  logic        cvt_en_o;
  logic [31:0] cvt_a_o;
  logic [31:0] cvt_z_i;
  logic        cvt_valid_i;
  logic        rsp_valid_o, rsp_id_o, rsp_err_o;
  logic [31:0] rsp_data_o;
  logic        rsp_ready_i;
  logic        busy_o;

  always #5 clk = ~clk;

  ibex_fp_cvt_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_valid_i(req_valid_i),
    .req_data0_i(req_data0_i),
    .req_data1_i(req_data1_i),
    .req_ready_o(req_ready_o),
    .cvt_en_o   (cvt_en_o),
    .cvt_a_o    (cvt_a_o),
    .cvt_z_i    (cvt_z_i),
    .cvt_valid_i(cvt_valid_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_id_o   (rsp_id_o),
    .rsp_data_o (rsp_data_o),
    .rsp_err_o  (rsp_err_o),
    .rsp_ready_i(rsp_ready_i),
    .busy_o     (busy_o)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_rsp   = 0;
  int n_en    = 0;

  typedef struct {
    logic        id;
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] i2f(input logic [31:0] a);
    logic        s;
    logic [31:0] m, mant, rem, half;
    logic [7:0]  e;
    int          p;
    if (a == 32'd0) return 32'd0;
    s = a[31];
    m = s ? (~a + 32'd1) : a;
    p = 31;
    while (!m[p]) p--;
    e = 8'(127 + p);
    if (p <= 23) begin
      mant = m << (23 - p);
    end else begin
      mant = m >> (p - 23);
      rem  = m & ((32'd1 << (p - 23)) - 32'd1);
      half = 32'd1 << (p - 24);
      if (rem > half || (rem == half && mant[0])) mant = mant + 32'd1;
      if (mant[24]) begin
        mant = mant >> 1;
        e    = e + 8'd1;
      end
    end
    return {s, e, mant[22:0]};
  endfunction

  // Behavioural converter: fixed latency, valid held for 'hold' cycles
  int          lat   = 2;
  int          hold  = 1;
  bit          stuck = 1'b0;
  int          m_cnt, m_vcnt;
  logic [31:0] m_z;
  logic        en_d;

  assign cvt_valid_i = (m_vcnt != 0);
  assign cvt_z_i     = m_z;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt  <= 0;
      m_vcnt <= 0;
      m_z    <= 32'd0;
    end else if (m_vcnt != 0) begin
      m_vcnt <= m_vcnt - 1;
    end else if (cvt_en_o && !stuck) begin
      if (m_cnt == lat) begin
        m_vcnt <= hold;
        m_z    <= i2f(cvt_a_o);
        m_cnt  <= 0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end else begin
      m_cnt <= 0;
    end
  end

  always @(posedge clk) begin
    en_d <= cvt_en_o;
    if (cvt_en_o && !en_d) n_en <= n_en + 1;
  end

  task automatic tick;
    exp_t e;
    #1;
    if (rsp_valid_o && rsp_ready_i) begin
      n_rsp++;
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_valid_o), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_id", 32'(rsp_id_o), 32'(e.id));
        chk("rsp_data", rsp_data_o, e.data);
        chk("rsp_err", 32'(rsp_err_o), 32'(e.err));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [1:0] v, input logic [31:0] d0,
                        input logic [31:0] d1, input logic [1:0] g,
                        input bit push, input logic [31:0] ed,
                        input logic ee);
    req_valid_i = v;
    req_data0_i = d0;
    req_data1_i = d1;
    #1;
    chk("grant", 32'(req_ready_o), 32'(g));
    if (push) sb.push_back('{id: g[1], data: ed, err: ee});
    @(posedge clk);
    #1;
    req_valid_i = v & ~g;
  endtask

  task automatic wait_idle(input int max);
    for (int i = 0; i < max; i++) begin
      if (!busy_o) break;
      tick();
    end
    if (busy_o) chk("idle_timeout", 32'(busy_o), 32'd0);
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 1;
    while (!rsp_valid_o && cyc < 40) begin
      tick();
      cyc++;
    end
    if (!rsp_valid_o) chk("rsp_timeout", 32'(rsp_valid_o), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, n0, e0, d;
    rst         = 1'b1;
    req_valid_i = 2'b00;
    req_data0_i = 32'd0;
    req_data1_i = 32'd0;
    rsp_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready_o), 32'd0);
    chk("rst_en", 32'(cvt_en_o), 32'd0);
    chk("rst_a", cvt_a_o, 32'd0);
    chk("rst_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_id", 32'(rsp_id_o), 32'd0);
    chk("rst_data", rsp_data_o, 32'd0);
    chk("rst_err", 32'(rsp_err_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    rst = 1'b0;
    tick();

    do_req(2'b01, 32'h1, 32'h0, 2'b01, 1, 32'h3F80_0000, 1'b0);
    wait_rsp(c);
    chk("latency", 32'(c), 32'd5);
    wait_idle(20);

    do_req(2'b10, 32'h0, 32'hFFFF_FFFF, 2'b10, 1, 32'hBF80_0000, 1'b0);
    wait_idle(20);

    do_req(2'b11, 32'd2, 32'd3, 2'b01, 1, 32'h4000_0000, 1'b0);
    wait_idle(20);
    do_req(2'b10, 32'd2, 32'd3, 2'b10, 1, 32'h4040_0000, 1'b0);
    wait_idle(20);
    do_req(2'b11, 32'd5, 32'd7, 2'b01, 1, 32'h40A0_0000, 1'b0);
    wait_idle(20);
    do_req(2'b10, 32'd5, 32'd7, 2'b10, 1, 32'h40E0_0000, 1'b0);
    wait_idle(20);

    rsp_ready_i = 1'b0;
    e0 = n_en;
    do_req(2'b01, 32'h8000_0000, 32'd0, 2'b01, 1, 32'hCF00_0000, 1'b0);
    wait_rsp(c);
    req_valid_i = 2'b10;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("hold_valid", 32'(rsp_valid_o), 32'd1);
      chk("hold_data", rsp_data_o, 32'hCF00_0000);
      chk("hold_id", 32'(rsp_id_o), 32'd0);
      chk("hold_ready", 32'(req_ready_o), 32'd0);
      chk("hold_en", 32'(cvt_en_o), 32'd0);
      @(posedge clk);
      #1;
    end
    chk("one_en", 32'(n_en - e0), 32'd1);
    req_valid_i = 2'b00;
    rsp_ready_i = 1'b1;
    wait_idle(20);

    do_req(2'b10, 32'd0, 32'd0, 2'b10, 1, 32'h0, 1'b0);
    wait_idle(20);

    hold = 3;
    n0 = n_rsp;
    do_req(2'b01, 32'd256, 32'd0, 2'b01, 1, 32'h4380_0000, 1'b0);
    wait_rsp(c);
    tick();
    d = 0;
    while (busy_o && d < 20) begin
      d++;
      tick();
    end
    chk("drain_cycles", 32'(d), 32'd2);
    chk("drain_cvt_valid", 32'(cvt_valid_i), 32'd0);
    repeat (4) tick();
    chk("one_rsp", 32'(n_rsp - n0), 32'd1);
    hold = 1;

    stuck = 1'b1;
    n0 = n_rsp;
    do_req(2'b01, 32'd9, 32'd0, 2'b01, 0, 32'h0, 1'b0);
    tick();
    tick();
    chk("wait_busy", 32'(busy_o), 32'd1);
    chk("wait_en", 32'(cvt_en_o), 32'd1);
    rst = 1'b1;
    #2;
    chk("mid_busy", 32'(busy_o), 32'd0);
    chk("mid_en", 32'(cvt_en_o), 32'd0);
    chk("mid_valid", 32'(rsp_valid_o), 32'd0);
    chk("mid_a", cvt_a_o, 32'd0);
    chk("mid_data", rsp_data_o, 32'd0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    stuck = 1'b0;
    do_req(2'b11, 32'd4, 32'd6, 2'b01, 1, 32'h4080_0000, 1'b0);
    wait_idle(20);
    do_req(2'b10, 32'd4, 32'd6, 2'b10, 1, 32'h40C0_0000, 1'b0);
    wait_idle(20);
    chk("post_rst_rsps", 32'(n_rsp - n0), 32'd2);

`ifdef IBEX_FP_CVT_TIMEOUT_EN
    stuck = 1'b1;
    do_req(2'b01, 32'd11, 32'd0, 2'b01, 1, 32'h7FC0_0000, 1'b1);
    wait_rsp(c);
    chk("to_latency", 32'(c), 32'd6);
    stuck = 1'b0;
    wait_idle(20);
`endif

    repeat (3) tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
